custom_op_scheduler: RTL and testbench
======================================

# custom_op_scheduler

Issue scheduler and shared pipeline for the custom bit-manipulation unit (BREV, BSWAP, CLZ, CPOP). It arbitrates between the two execute issue slots of the dual-issue core (slot 0 = exec0, slot 1 = exec1) and grants at most one operation per cycle. Granted operations travel through a fixed-latency pipeline that carries an owner tag. Each result is routed back to the slot that issued it, and in-flight work is discarded on a per-slot pipeline flush.

## Interface
- LATENCY, 2, issue-to-response latency in cycles; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_valid_i  in  1  slot 0 has an operation.
- req0_ready_o  out  1  slot 0 granted this cycle.
- req0_op_i  in  2  op code: 00 BREV, 01 BSWAP, 10 CLZ, 11 CPOP.
- req0_data_i  in  32  source operand.
- req0_rd_i  in  5  destination register tag.
- req1_valid_i, req1_ready_o, req1_op_i, req1_data_i, req1_rd_i: same as slot 0, for slot 1.
- flush0_i  in  1  kill all slot-0 work (mispredict or exception).
- flush1_i  in  1  kill all slot-1 work.
- resp0_valid_o  out  1  result for slot 0, single-cycle pulse.
- resp0_data_o  out  32  result value.
- resp0_rd_o  out  5  destination tag.
- resp1_valid_o, resp1_data_o, resp1_rd_o: same as slot 0, for slot 1.
- busy_o  out  1  at least one pipeline stage is valid.

## Operation
- **Result computation**
  - Computed combinationally at issue from the granted request.
  - BREV: result[i] = data[31-i].
  - BSWAP: byte order reversed.
  - CLZ: count of leading zeros, 0..32 (32 when the operand is 0).
  - CPOP: count of set bits, 0..32.
  - CLZ and CPOP results are zero-extended to 32 bits.
- **Arbitration**
  - Round-robin pointer `rr` selects the preferred slot; reset value 0.
  - Both slots eligible: grant slot `rr`.
  - One slot eligible: grant that slot.
  - After any grant, `rr` becomes the slot that was not granted.
  - No grant: `rr` holds.
  - Eligible = reqN_valid_i and not flushN_i.
- **Handshake**
  - reqN_ready_o equals grantN and is combinational from the valid, flush and `rr` inputs.
  - A transfer occurs when valid and ready are both high at a rising edge.
  - The requester holds op, data and rd stable until the transfer.
  - The unit is fully pipelined and never stalls; at most one grant per cycle.
- **Pipeline**
  - LATENCY stages, each holding {valid, owner, rd, result}.
  - Stage 0 loads the granted operation; each stage shifts every cycle.
  - The last stage drives respN_* for its owner; the other slot's resp_valid stays 0.
  - Responses have no back-pressure; requesters always accept them.
- **Flush**
  - flushN_i high at an edge clears valid on every stage whose owner is N.
  - A slot-N response being presented in that same cycle is still delivered, because it was registered before the flush.
  - The flushed slot is not granted during a flush cycle; the other slot is unaffected.
  - Simultaneous flush0 and flush1 empty the pipeline.
- **Reset**
  - rst low at any time, including mid-operation, immediately clears all stage valids and `rr`.
  - In-flight results are discarded with no response.
  - Reset values: every resp*_valid_o 0, resp*_data_o 0, resp*_rd_o 0, busy_o 0.
  - req*_ready_o is 0 while rst is low.

## Timing
- Transfer at edge t: the response is visible from edge t+LATENCY-1 until edge t+LATENCY. With LATENCY=1 it is valid in the cycle directly after the transfer.
- Throughput: 1 operation per cycle in aggregate; at most LATENCY operations in flight.
- Responses leave in issue order, so back-to-back grants give back-to-back responses.
- busy_o is registered and is the OR of the stage valids.

## Structure
- Shared package `custom_op_pkg` holds:
  - op-code constants OP_BREV, OP_BSWAP, OP_CLZ, OP_CPOP;
  - the stage struct type {valid, owner, rd[4:0], result[31:0]};
  - the LATENCY bounds.
- One natural sub-module: `custom_bitop_core`, the purely combinational op/data to result function. Verify it standalone as well.
- The arbiter, pipeline shift register and response demux live in the top module.

## Test plan
- Single slot 0, LATENCY=2, BREV 0x00000001 (rd 5): resp0 = 0x80000000 with rd 5 exactly 2 cycles after transfer; resp1_valid stays 0.
- Op coverage, slot 1, issued back-to-back:
  - BSWAP 0x12345678 -> 0x78563412;
  - CLZ 0x00010000 -> 15;
  - CLZ 0 -> 32;
  - CPOP 0xF0F0F0F0 -> 16;
  - responses appear on consecutive cycles.
- Both slots valid for 4 cycles from reset: grant order 0,1,0,1. Then slot 1 alone for 2 cycles: grants 1,1. Then both valid: grant 0, since `rr` = 0 after the last slot-1 grant.
- With slot-0 and slot-1 ops interleaved in flight, assert flush0_i for one cycle:
  - no slot-0 response follows except one already presented in that cycle;
  - all slot-1 responses arrive unchanged;
  - req0_ready_o = 0 during the flush cycle.
- Pipeline full (LATENCY=4, 4 ops in flight): drive rst low for 1 cycle mid-stream. No responses afterwards, busy_o = 0 immediately, and the first post-reset grant goes to slot 0.

Source files
------------

// File: rtl/custom_op_pkg.sv
// Shared types and constants for the custom bit-manipulation unit.
// Op codes, pipeline stage bundle and latency bounds.
package custom_op_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    localparam logic [1:0] OP_BREV  = 2'b00;
    localparam logic [1:0] OP_BSWAP = 2'b01;
    localparam logic [1:0] OP_CLZ   = 2'b10;
    localparam logic [1:0] OP_CPOP  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        owner;
        logic [4:0]  rd;
        logic [31:0] result;
    } stage_t;

endpackage

// File: rtl/custom_bitop_core.sv
// Combinational result function for BREV, BSWAP, CLZ and CPOP.
// Pure op/data to result mapping with no state.
module custom_bitop_core
    import custom_op_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [31:0] brev;
    logic [5:0]  clz;
    logic [5:0]  cpop;

    always_comb begin
        brev = '0;
        clz  = 6'd32;
        cpop = '0;
        for (int i = 0; i < 32; i++) begin
            brev[i] = data_i[31-i];
            // highest set bit is visited last and wins
            if (data_i[i]) clz = 6'(31 - i);
            cpop = cpop + {5'd0, data_i[i]};
        end
    end

    always_comb begin
        result_o = '0;
        unique case (op_i)
            OP_BREV:  result_o = brev;
            OP_BSWAP: result_o = {data_i[7:0], data_i[15:8],
                                  data_i[23:16], data_i[31:24]};
            OP_CLZ:   result_o = {26'd0, clz};
            OP_CPOP:  result_o = {26'd0, cpop};
        endcase
    end

endmodule

// File: rtl/custom_op_scheduler.sv
// Two-slot round-robin issue scheduler feeding a fixed-latency
// bit-op pipeline with owner-tagged results and per-slot flush.
module custom_op_scheduler
    import custom_op_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [1:0]  req0_op_i,
    input  logic [31:0] req0_data_i,
    input  logic [4:0]  req0_rd_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [1:0]  req1_op_i,
    input  logic [31:0] req1_data_i,
    input  logic [4:0]  req1_rd_i,
    input  logic        flush0_i,
    input  logic        flush1_i,
    output logic        resp0_valid_o,
    output logic [31:0] resp0_data_o,
    output logic [4:0]  resp0_rd_o,
    output logic        resp1_valid_o,
    output logic [31:0] resp1_data_o,
    output logic [4:0]  resp1_rd_o,
    output logic        busy_o
);

    stage_t [LATENCY-1:0] stage_q, stage_d;
    logic                 rr_q, rr_d;
    logic                 busy_q, busy_d;

    logic        elig0, elig1;
    logic        grant0, grant1;
    logic [1:0]  core_op;
    logic [31:0] core_res;
    stage_t      last;

    assign elig0  = req0_valid_i & ~flush0_i;
    assign elig1  = req1_valid_i & ~flush1_i;
    assign grant0 = rst & elig0 & (~elig1 | ~rr_q);
    assign grant1 = rst & elig1 & (~elig0 | rr_q);

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    assign core_op = grant1 ? req1_op_i : req0_op_i;

    custom_bitop_core u_core (
        .op_i     (core_op),
        .data_i   (grant1 ? req1_data_i : req0_data_i),
        .result_o (core_res)
    );

    always_comb begin
        stage_d = stage_q;
        stage_d[0].valid  = grant0 | grant1;
        stage_d[0].owner  = grant1;
        stage_d[0].rd     = grant1 ? req1_rd_i : req0_rd_i;
        stage_d[0].result = core_res;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // the last stage shifts out untouched, so a response
        // already on the outputs survives its own flush
        for (int i = 0; i < LATENCY; i++) begin
            if ((flush0_i && !stage_d[i].owner) ||
                (flush1_i && stage_d[i].owner)) begin
                stage_d[i].valid = 1'b0;
            end
        end
        busy_d = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy_d = busy_d | stage_d[i].valid;
        end
        rr_d = rr_q;
        if (grant0)      rr_d = 1'b1;
        else if (grant1) rr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= '0;
            rr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    assign last   = stage_q[LATENCY-1];
    assign busy_o = busy_q;

    assign resp0_valid_o = last.valid & ~last.owner;
    assign resp1_valid_o = last.valid & last.owner;
    assign resp0_data_o  = resp0_valid_o ? last.result : '0;
    assign resp1_data_o  = resp1_valid_o ? last.result : '0;
    assign resp0_rd_o    = resp0_valid_o ? last.rd : '0;
    assign resp1_rd_o    = resp1_valid_o ? last.rd : '0;

endmodule

// File: tb/tb_custom_op_scheduler.sv
// Bench for custom_op_scheduler at LATENCY 2 and 4 sharing one
// stimulus stream, plus the standalone bit-op core.
module tb_custom_op_scheduler;
    import custom_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 0, v1 = 0, f0 = 0, f1 = 0;
    logic [1:0]  op0 = 0, op1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    logic [4:0]  rd0 = 0, rd1 = 0;

    logic        rdy0[2], rdy1[2], rv0[2], rv1[2], busy[2];
    logic [31:0] rdata0[2], rdata1[2];
    logic [4:0]  rrd0[2], rrd1[2];

    logic [1:0]  c_op;
    logic [31:0] c_data, c_res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rr_m = 0;
    bit gs0, gs1;
    int lat[2] = '{2, 4};

    typedef struct {
        int          t;
        bit          own;
        logic [4:0]  rd;
        logic [31:0] res;
        bit          dead[2];
    } txn_t;
    txn_t q[$];

    always #5 clk = ~clk;

    custom_op_scheduler #(.LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0[0]), .req0_op_i(op0),
        .req0_data_i(d0), .req0_rd_i(rd0),
        .req1_valid_i(v1), .req1_ready_o(rdy1[0]), .req1_op_i(op1),
        .req1_data_i(d1), .req1_rd_i(rd1),
        .flush0_i(f0), .flush1_i(f1),
        .resp0_valid_o(rv0[0]), .resp0_data_o(rdata0[0]), .resp0_rd_o(rrd0[0]),
        .resp1_valid_o(rv1[0]), .resp1_data_o(rdata1[0]), .resp1_rd_o(rrd1[0]),
        .busy_o(busy[0])
    );

    custom_op_scheduler #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid_i(v0), .req0_ready_o(rdy0[1]), .req0_op_i(op0),
        .req0_data_i(d0), .req0_rd_i(rd0),
        .req1_valid_i(v1), .req1_ready_o(rdy1[1]), .req1_op_i(op1),
        .req1_data_i(d1), .req1_rd_i(rd1),
        .flush0_i(f0), .flush1_i(f1),
        .resp0_valid_o(rv0[1]), .resp0_data_o(rdata0[1]), .resp0_rd_o(rrd0[1]),
        .resp1_valid_o(rv1[1]), .resp1_data_o(rdata1[1]), .resp1_rd_o(rrd1[1]),
        .busy_o(busy[1])
    );

    custom_bitop_core u_core (
        .op_i(c_op), .data_i(c_data), .result_o(c_res)
    );

    function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] d);
        logic [31:0] r;
        int n;
        r = '0;
        case (op)
            2'd0: for (int i = 0; i < 32; i++) r[i] = d[31-i];
            2'd1: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
            2'd2: begin
                n = 0;
                while (n < 32 && d[31-n] == 1'b0) n++;
                r = n;
            end
            default: r = $countones(d);
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp();
        bit ev0, ev1, eb;
        logic [31:0] ed0, ed1;
        logic [4:0] er0, er1;
        int l;
        for (int k = 0; k < 2; k++) begin
            l = lat[k];
            ev0 = 0; ev1 = 0; eb = 0;
            ed0 = '0; ed1 = '0; er0 = '0; er1 = '0;
            foreach (q[i]) begin
                if (!q[i].dead[k] && q[i].t + l - 1 == cyc) begin
                    if (q[i].own) begin
                        ev1 = 1; ed1 = q[i].res; er1 = q[i].rd;
                    end else begin
                        ev0 = 1; ed0 = q[i].res; er0 = q[i].rd;
                    end
                end
                if (!q[i].dead[k] && q[i].t <= cyc && cyc <= q[i].t + l - 1)
                    eb = 1;
            end
            chk($sformatf("resp0_valid_L%0d", l), rv0[k], ev0);
            chk($sformatf("resp0_data_L%0d", l), rdata0[k], ed0);
            chk($sformatf("resp0_rd_L%0d", l), rrd0[k], er0);
            chk($sformatf("resp1_valid_L%0d", l), rv1[k], ev1);
            chk($sformatf("resp1_data_L%0d", l), rdata1[k], ed1);
            chk($sformatf("resp1_rd_L%0d", l), rrd1[k], er1);
            chk($sformatf("busy_L%0d", l), busy[k], eb);
        end
        while (q.size() > 0 && q[0].t + 3 <= cyc) void'(q.pop_front());
    endtask

    task automatic step(input bit a0, input logic [1:0] o0,
                        input logic [31:0] x0, input logic [4:0] t0,
                        input bit a1, input logic [1:0] o1,
                        input logic [31:0] x1, input logic [4:0] t1,
                        input bit fl0, input bit fl1);
        bit e0, e1, g0, g1;
        txn_t n;
        v0 = a0; op0 = o0; d0 = x0; rd0 = t0;
        v1 = a1; op1 = o1; d1 = x1; rd1 = t1;
        f0 = fl0; f1 = fl1;
        #1;
        e0 = a0 && !fl0;
        e1 = a1 && !fl1;
        g0 = e0 && (!e1 || rr_m == 0);
        g1 = e1 && (!e0 || rr_m == 1);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready0_L%0d", lat[k]), rdy0[k], g0);
            chk($sformatf("ready1_L%0d", lat[k]), rdy1[k], g1);
        end
        gs0 = rdy0[0];
        gs1 = rdy1[0];
        @(posedge clk);
        cyc++;
        foreach (q[i]) begin
            if ((fl0 && !q[i].own) || (fl1 && q[i].own)) begin
                for (int k = 0; k < 2; k++)
                    if (q[i].t + lat[k] - 1 >= cyc) q[i].dead[k] = 1;
            end
        end
        if (g0 || g1) begin
            n.t = cyc;
            n.own = g1;
            n.rd = g1 ? t1 : t0;
            n.res = g1 ? ref_op(o1, x1) : ref_op(o0, x0);
            n.dead[0] = 0;
            n.dead[1] = 0;
            q.push_back(n);
        end
        if (g0) rr_m = 1;
        else if (g1) rr_m = 0;
        @(negedge clk);
        check_resp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_ready0"}, rdy0[k], 0);
            chk({tag, "_ready1"}, rdy1[k], 0);
            chk({tag, "_rv0"}, rv0[k], 0);
            chk({tag, "_rv1"}, rv1[k], 0);
            chk({tag, "_data0"}, rdata0[k], 0);
            chk({tag, "_data1"}, rdata1[k], 0);
            chk({tag, "_rd0"}, rrd0[k], 0);
            chk({tag, "_rd1"}, rrd1[k], 0);
            chk({tag, "_busy"}, busy[k], 0);
        end
    endtask

    task automatic hard_reset(input string tag);
        v0 = 1; v1 = 1; f0 = 0; f1 = 0;
        #2;
        rst = 0;
        #1;
        chk_zero(tag);
        q.delete();
        rr_m = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1;
        v0 = 0; v1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen[$];
        int seen_cyc[$];
        int exp_g[7] = '{0, 1, 0, 1, 1, 1, 0};
        bit both[7]  = '{1, 1, 1, 1, 0, 0, 1};
        logic [31:0] exp_v[4] = '{32'h78563412, 32'd15, 32'd32, 32'd16};
        logic [1:0]  ops[4] = '{OP_BSWAP, OP_CLZ, OP_CLZ, OP_CPOP};
        logic [31:0] dat[4] = '{32'h12345678, 32'h00010000, 32'h0, 32'hF0F0F0F0};
        bit p0, p1;

        // standalone core
        c_op = OP_BREV; c_data = 32'h1; #1;
        chk("core_brev", c_res, 32'h80000000);
        c_op = OP_BSWAP; c_data = 32'h12345678; #1;
        chk("core_bswap", c_res, 32'h78563412);
        c_op = OP_CLZ; c_data = 32'h00010000; #1;
        chk("core_clz", c_res, 32'd15);
        c_op = OP_CLZ; c_data = 32'h0; #1;
        chk("core_clz0", c_res, 32'd32);
        c_op = OP_CPOP; c_data = 32'hF0F0F0F0; #1;
        chk("core_cpop", c_res, 32'd16);
        c_op = OP_CPOP; c_data = 32'hFFFFFFFF; #1;
        chk("core_cpop_all", c_res, 32'd32);
        for (int i = 0; i < 40; i++) begin
            c_op = 2'($urandom);
            c_data = $urandom;
            if (i % 8 == 0) c_data = c_data >> $urandom_range(0, 31);
            #1;
            chk("core_rand", c_res, ref_op(c_op, c_data));
        end

        // reset state
        v0 = 1; v1 = 1;
        #1;
        chk_zero("reset");
        @(negedge clk);
        v0 = 0; v1 = 0;
        rst = 1;

        // single BREV on slot 0
        step(1, OP_BREV, 32'h1, 5'd5, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("brev_valid", rv0[0], 1);
        chk("brev_data", rdata0[0], 32'h80000000);
        chk("brev_rd", rrd0[0], 5'd5);
        chk("brev_other", rv1[0], 0);
        idle(4);

        // op coverage on slot 1, back-to-back
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(0, 0, 0, 0, 1, ops[i], dat[i], 5'(i + 1), 0, 0);
            else idle(1);
            if (rv1[0]) begin
                seen.push_back(rdata1[0]);
                seen_cyc.push_back(cyc);
            end
        end
        chk("opcov_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk("opcov_value", seen[i], exp_v[i]);
            chk("opcov_consec", seen_cyc[i], seen_cyc[0] + i);
        end

        // grant order from reset
        hard_reset("rst_a");
        for (int i = 0; i < 7; i++) begin
            step(both[i], OP_CPOP, 32'h0000_00FF, 5'(10 + i),
                 1, OP_CLZ, 32'h0000_0F00, 5'(20 + i), 0, 0);
            chk("grant_any", gs0 | gs1, 1);
            chk("grant_order", gs1, exp_g[i]);
        end
        idle(5);

        // flush0 with interleaved traffic
        step(1, OP_BREV, 32'hA5A5_0001, 5'd1, 1, OP_BSWAP, 32'hCAFE_BABE, 5'd2, 0, 0);
        step(1, OP_CLZ, 32'h0000_0100, 5'd3, 1, OP_CPOP, 32'h1234_5678, 5'd4, 0, 0);
        step(1, OP_CPOP, 32'h0F0F_0F0F, 5'd5, 1, OP_BREV, 32'h8000_0003, 5'd6, 0, 0);
        step(1, OP_BSWAP, 32'h0102_0304, 5'd7, 1, OP_CLZ, 32'h0000_0001, 5'd8, 1, 0);
        chk("flush_ready0", gs0, 0);
        chk("flush_ready1", gs1, 1);
        idle(6);

        // reset mid-stream with four ops in flight
        for (int i = 0; i < 4; i++)
            step(1, OP_CPOP, $urandom, 5'(i), 1, OP_BREV, $urandom, 5'(i + 8), 0, 0);
        chk("full_busy", busy[1], 1);
        hard_reset("rst_mid");
        step(1, OP_BREV, 32'h3, 5'd9, 1, OP_CLZ, 32'h1, 5'd10, 0, 0);
        chk("post_rst_grant0", gs0, 1);
        chk("post_rst_grant1", gs1, 0);
        idle(6);

        // randomized traffic with flushes
        p0 = 0; p1 = 0;
        for (int i = 0; i < 300; i++) begin
            bit a0, a1, fl0, fl1;
            logic [1:0] o0, o1;
            logic [31:0] x0, x1;
            logic [4:0] t0, t1;
            if (p0) begin
                a0 = 1; o0 = op0; x0 = d0; t0 = rd0;
            end else begin
                a0 = $urandom_range(0, 3) != 0;
                o0 = 2'($urandom); x0 = $urandom; t0 = 5'($urandom);
            end
            if (p1) begin
                a1 = 1; o1 = op1; x1 = d1; t1 = rd1;
            end else begin
                a1 = $urandom_range(0, 3) != 0;
                o1 = 2'($urandom); x1 = $urandom; t1 = 5'($urandom);
            end
            fl0 = $urandom_range(0, 9) == 0;
            fl1 = $urandom_range(0, 9) == 0;
            step(a0, o0, x0, t0, a1, o1, x1, t1, fl0, fl1);
            p0 = a0 && !gs0 && !fl0;
            p1 = a1 && !gs1 && !fl1;
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
